// File: rtl/sigmoid_grad_if.sv
// Handshake bundle between the activation output buffer and the gradient unit.
// Carries the y input channel, the gradient output channel and the busy flag.
// Optional SIGMOID_GRAD_ERR_EN adds the back-propagated error operand in_err.
interface sigmoid_grad_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_y;
`ifdef SIGMOID_GRAD_ERR_EN
    logic [31:0] in_err;
`endif
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_grad;
    logic        busy;

`ifdef SIGMOID_GRAD_ERR_EN
    modport master (output in_valid, in_y, in_err, out_ready,
                    input  in_ready, out_valid, out_grad, busy);
    modport slave  (input  in_valid, in_y, in_err, out_ready,
                    output in_ready, out_valid, out_grad, busy);
`else
    modport master (output in_valid, in_y, out_ready,
                    input  in_ready, out_valid, out_grad, busy);
    modport slave  (input  in_valid, in_y, out_ready,
                    output in_ready, out_valid, out_grad, busy);
`endif
endinterface

// File: rtl/sigmoid_grad.sv
// Sigmoid backward gradient y*(1-y) on float32 via a sequential shift-add mantissa multiplier.
// Latency: out_valid rises N+2 edges after acceptance (2N+3 with SIGMOID_GRAD_ERR_EN), N=24/BITS_PER_CYCLE.
// Backpressure: one operation in flight; in_ready only in IDLE; result held in DONE until out_ready.
// Optional macro SIGMOID_GRAD_ERR_EN: second pass multiplies by in_err (delta = err*y*(1-y)).
module sigmoid_grad #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rstn,
    sigmoid_grad_if.slave bus
);
    localparam int N  = 24 / BITS_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {IDLE, PREP, MUL, NORM, DONE} state_t;

    state_t             state_q;
    logic [31:0]        y_q;
    logic               zero_q;
    logic signed [10:0] ea_q;
    logic signed [10:0] eb_q;
    logic [47:0]        mcand_q;
    logic [23:0]        mplier_q;
    logic [47:0]        acc_q;
    logic [CW-1:0]      cnt_q;
    logic [31:0]        out_grad_q;
    logic               out_valid_q;
    logic               in_ready_q;
    logic               busy_q;
`ifdef SIGMOID_GRAD_ERR_EN
    logic [31:0]        err_q;
    logic               pass_q;
`endif

    logic [7:0]         e_y, s_y;
    logic [24:0]        a_y, d_y, md_ext;
    logic [4:0]         k_y;
    logic [23:0]        md_y;
    logic signed [10:0] expd_y;
    logic               prep_zero;
    logic [47:0]        sum_m;
    logic signed [10:0] exp_n;
    logic [22:0]        mant_n;
    logic               flush_n;
    logic [31:0]        res_n;
    logic               unused_bits;

    // Compute D = 1-y, normalise it to a 24-bit mantissa and its biased exponent
    always_comb begin
        e_y       = y_q[30:23];
        s_y       = 8'd127 - e_y;
        prep_zero = y_q[31] || (e_y >= 8'd127) || (e_y == 8'd0);
        a_y       = {1'b1, y_q[22:0], 1'b0} >> s_y;
        d_y       = (s_y >= 8'd26) ? 25'h100_0000 : 25'h100_0000 - a_y;
        k_y       = 5'd0;
        for (int i = 0; i < 25; i++) begin
            if (d_y[i]) k_y = 5'(i);
        end
        md_ext    = d_y << (5'd24 - k_y);
        md_y      = md_ext[24:1];
        expd_y    = 11'sd103 + $signed({6'b0, k_y});
    end

    // Retire BITS_PER_CYCLE multiplier bits (LSB first) into the accumulator
    always_comb begin
        sum_m = acc_q;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mplier_q[i]) sum_m = sum_m + (mcand_q << i);
        end
    end

    // Normalise the 48-bit product; truncate, flush tiny results, saturate huge ones
    always_comb begin
        exp_n   = ea_q + eb_q - 11'sd127 + $signed({10'b0, acc_q[47]});
        mant_n  = acc_q[47] ? acc_q[46:24] : acc_q[45:23];
        flush_n = zero_q || (exp_n <= 11'sd0);
        if (flush_n) begin
            res_n = '0;
        end else if (exp_n >= 11'sd255) begin
            // only reachable when scaling by a large in_err
            res_n = 32'h7F80_0000;
        end else begin
            res_n = {1'b0, exp_n[7:0], mant_n};
        end
    end

    assign unused_bits = ^{acc_q[22:0], md_ext[0]};

    // Control FSM and datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            y_q         <= '0;
            zero_q      <= 1'b0;
            ea_q        <= '0;
            eb_q        <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_grad_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
`ifdef SIGMOID_GRAD_ERR_EN
            err_q       <= '0;
            pass_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        y_q        <= bus.in_y;
`ifdef SIGMOID_GRAD_ERR_EN
                        err_q      <= bus.in_err;
`endif
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= PREP;
                    end
                end
                PREP: begin
                    zero_q   <= prep_zero;
                    ea_q     <= {3'b0, e_y};
                    eb_q     <= expd_y;
                    mcand_q  <= {24'b0, 1'b1, y_q[22:0]};
                    mplier_q <= md_y;
                    acc_q    <= '0;
                    cnt_q    <= '0;
                    state_q  <= MUL;
                end
                MUL: begin
                    acc_q    <= sum_m;
                    mcand_q  <= mcand_q << BITS_PER_CYCLE;
                    mplier_q <= mplier_q >> BITS_PER_CYCLE;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CW'(N - 1)) state_q <= NORM;
                end
                NORM: begin
`ifdef SIGMOID_GRAD_ERR_EN
                    if (!pass_q) begin
                        // second pass: scale y*(1-y) by the error operand
                        pass_q   <= 1'b1;
                        zero_q   <= flush_n || (err_q[30:23] == 8'h00) || (err_q[30:23] == 8'hFF);
                        ea_q     <= exp_n;
                        eb_q     <= {3'b0, err_q[30:23]};
                        mcand_q  <= {24'b0, 1'b1, mant_n};
                        mplier_q <= {1'b1, err_q[22:0]};
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        state_q  <= MUL;
                    end else begin
                        pass_q      <= 1'b0;
                        out_grad_q  <= (res_n == '0) ? '0 : {err_q[31], res_n[30:0]};
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
`else
                    out_grad_q  <= res_n;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
`endif
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_grad  = out_grad_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_sigmoid_grad.sv
// Scoreboard bench for sigmoid_grad: directed y vectors on a 1-bit/cycle and an 8-bit/cycle instance.
// Stimulus pushes expected gradient and latency; a negedge monitor pops and compares on out_valid.
// Also covers output stall, mid-multiply reset and post-handshake return to IDLE.
module tb_sigmoid_grad;
`ifdef SIGMOID_GRAD_ERR_EN
    localparam int LAT0 = 2 * 24 + 3;
    localparam int LAT1 = 2 * 3 + 3;
`else
    localparam int LAT0 = 24 + 2;
    localparam int LAT1 = 3 + 2;
`endif

    typedef struct {
        logic [31:0] val;
        int          acc;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rstn0 = 1'b1;
    logic rstn1 = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t q0[$];
    exp_t q1[$];
    bit          prev_v[2];
    bit          hs_pend[2];
    logic [31:0] held[2];

    sigmoid_grad_if if0 ();
    sigmoid_grad_if if1 ();

    sigmoid_grad #(.BITS_PER_CYCLE(1)) u0 (.clk(clk), .rstn(rstn0), .bus(if0));
    sigmoid_grad #(.BITS_PER_CYCLE(8)) u1 (.clk(clk), .rstn(rstn1), .bus(if1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, expv);
        end
    endtask

    function automatic logic get_ir(input int d);
        return (d == 0) ? if0.in_ready : if1.in_ready;
    endfunction

    task automatic drive(input int d, input logic v, input logic [31:0] y);
        if (d == 0) begin
            if0.in_valid = v;
            if0.in_y     = y;
        end else begin
            if1.in_valid = v;
            if1.in_y     = y;
        end
    endtask

    // Present y, wait (bounded) for acceptance, then scramble in_y to prove it is not re-sampled
    task automatic send(input int d, input logic [31:0] y, input logic [31:0] expv, input bit push);
        int   n;
        bit   ok;
        exp_t e;
        n  = 0;
        ok = 0;
        @(negedge clk);
        drive(d, 1'b1, y);
        while (!ok && n < 300) begin
            if (get_ir(d)) ok = 1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout dut%0d: in_ready got 0 want 1", d);
        end else begin
            e.val = expv;
            e.acc = cyc + 1;
            e.lat = (d == 0) ? LAT0 : LAT1;
            @(posedge clk);
            #1;
            if (push) begin
                if (d == 0) q0.push_back(e);
                else q1.push_back(e);
            end
        end
        drive(d, 1'b0, $urandom());
    endtask

    task automatic check_reset(input int d);
        if (d == 0) begin
            chk("rst_ctl0", {29'b0, if0.out_valid, if0.in_ready, if0.busy}, 32'h2);
            chk("rst_grad0", if0.out_grad, 32'h0);
        end else begin
            chk("rst_ctl1", {29'b0, if1.out_valid, if1.in_ready, if1.busy}, 32'h2);
            chk("rst_grad1", if1.out_grad, 32'h0);
        end
    endtask

    task automatic drain(input int d);
        int n;
        n = 0;
        while (n < 300 && !((d == 0) ? (q0.size() == 0 && !if0.out_valid && if0.in_ready)
                                     : (q1.size() == 0 && !if1.out_valid && if1.in_ready))) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("drain%0d_left", d), (d == 0) ? q0.size() : q1.size(), 32'd0);
    endtask

    task automatic mon_step(input int d);
        logic        v, ir, b, orr, rs;
        logic [31:0] g;
        exp_t        e;
        if (d == 0) begin
            v = if0.out_valid; ir = if0.in_ready; b = if0.busy; orr = if0.out_ready; g = if0.out_grad; rs = rstn0;
        end else begin
            v = if1.out_valid; ir = if1.in_ready; b = if1.busy; orr = if1.out_ready; g = if1.out_grad; rs = rstn1;
        end
        if (!rs) begin
            prev_v[d]  = 0;
            hs_pend[d] = 0;
            return;
        end
        if (hs_pend[d]) begin
            // the cycle after the handshake must be IDLE: valid low, ready high, not busy
            chk($sformatf("idle_after_hs%0d", d), {29'b0, v, ir, b}, 32'h2);
            hs_pend[d] = 0;
        end
        if (v && !prev_v[d]) begin
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                total++;
                bad++;
                $display("FAIL unexpected_out dut%0d: got %h want no output", d, g);
            end else begin
                if (d == 0) e = q0.pop_front();
                else e = q1.pop_front();
                chk($sformatf("grad%0d", d), g, e.val);
                chk($sformatf("latency%0d", d), 32'(cyc - e.acc), 32'(e.lat));
            end
            held[d] = g;
        end else if (v) begin
            chk($sformatf("stall_grad%0d", d), g, held[d]);
            chk($sformatf("stall_ctl%0d", d), {30'b0, ir, b}, 32'h1);
        end
        if (v && orr) hs_pend[d] = 1;
        prev_v[d] = v;
    endtask

    always @(negedge clk) begin
        mon_step(0);
        mon_step(1);
    end

    logic [31:0] vec_y [9] = '{32'h3F00_0000, 32'h3F40_0000, 32'h3E80_0000, 32'h3F80_0000, 32'hBF00_0000,
                               32'h0000_0000, 32'h7FC0_0000, 32'h3080_0000, 32'h3F7F_FFFF};
    // 0x3F7FFFFF: y*(1-y) = (1-2^-24)*2^-24, just below 2^-24 -> exponent 102, mantissa all ones
    logic [31:0] vec_g [9] = '{32'h3E80_0000, 32'h3E40_0000, 32'h3E40_0000, 32'h0000_0000, 32'h0000_0000,
                               32'h0000_0000, 32'h0000_0000, 32'h3080_0000, 32'h337F_FFFF};

    initial begin
        int n;
        if0.in_valid = 0; if0.in_y = 0; if0.out_ready = 1;
        if1.in_valid = 0; if1.in_y = 0; if1.out_ready = 1;
`ifdef SIGMOID_GRAD_ERR_EN
        if0.in_err = 32'h3F80_0000;
        if1.in_err = 32'h3F80_0000;
`endif
        #2;
        rstn0 = 0;
        rstn1 = 0;
        #1;
        check_reset(0);
        check_reset(1);
        repeat (2) @(negedge clk);
        rstn0 = 1;
        rstn1 = 1;

        for (int i = 0; i < 9; i++) send(0, vec_y[i], vec_g[i], 1);
        drain(0);

        // Output stall: hold out_ready low ~10 cycles while a second input waits
        if0.out_ready = 0;
        send(0, 32'h3F00_0000, 32'h3E80_0000, 1);
        n = 0;
        while (!if0.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("stall_reached_done", {31'b0, if0.out_valid}, 32'h1);
        fork
            send(0, 32'h3F40_0000, 32'h3E40_0000, 1);
            begin
                repeat (10) @(posedge clk);
                #1;
                if0.out_ready = 1;
            end
        join
        drain(0);

        // Reset in the middle of the multiply: aborted item must produce nothing
        send(0, 32'h3F00_0000, 32'h0, 0);
        repeat (3) @(posedge clk);
        #1;
        rstn0 = 0;
        #1;
        check_reset(0);
        @(negedge clk);
        rstn0 = 1;
        send(0, 32'h3F00_0000, 32'h3E80_0000, 1);
        drain(0);

        // 8 bits per cycle instance
        send(1, 32'h3F00_0000, 32'h3E80_0000, 1);
        send(1, 32'h3F00_0000, 32'h0, 0);
        @(posedge clk);
        #1;
        rstn1 = 0;
        #1;
        check_reset(1);
        @(negedge clk);
        rstn1 = 1;
        send(1, 32'h3F00_0000, 32'h3E80_0000, 1);
        send(1, 32'h3F7F_FFFF, 32'h337F_FFFF, 1);
        send(1, 32'h3E80_0000, 32'h3E40_0000, 1);
        send(1, 32'h3F80_0000, 32'h0000_0000, 1);
        drain(1);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
